// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: issues one dcache access per memory instruction, stalls the
// pipeline until dhit, and holds the per-core LR/SC reservation.
module mem_access_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             req_valid,
   input  logic             req_ren,
   input  logic             req_wen,
   input  logic             req_atomic,
   input  logic             req_halt,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_store,
   input  logic             latch_adv,
   input  logic             dhit,
   input  logic [31:0]      dmemload,
   input  logic             snoop_inval,
   input  logic [31:0]      snoop_addr,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic [31:0]      dmemaddr,
   output logic [31:0]      dmemstore,
   output logic [31:0]      load_data,
   output logic             sc_fail,
   output logic             mem_stall,
   output logic             memwb_flush,
   output logic             link_valid,
   output logic [31:0]      link_addr,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t             state_reg, state_next;
   logic               link_valid_reg, link_valid_next;
   logic [31:0]        link_addr_reg, link_addr_next;
   logic [31:0]        load_data_reg, load_data_next;
   logic               sc_fail_reg, sc_fail_next;
   logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;

   logic mem_op, is_lr, is_sc, sc_bad, complete, sc_now;
   logic unused_bits;

   assign unused_bits = ^snoop_addr[1:0];
   assign mem_op = req_valid & (req_ren | req_wen) & ~req_halt;
   assign is_lr  = req_atomic & req_ren;
   assign is_sc  = req_atomic & req_wen;
   assign sc_bad = is_sc & ~(link_valid_reg & (link_addr_reg[31:2] == req_addr[31:2]));

   // Address/data pass straight through but are forced low while reset is asserted.
   assign dmemaddr  = nRST ? req_addr  : 32'h0;
   assign dmemstore = nRST ? req_store : 32'h0;

   assign link_valid   = link_valid_reg;
   assign link_addr    = link_addr_reg;
   assign stall_cycles = stall_cnt_reg;

   always_comb begin
      state_next  = state_reg;
      dmemREN     = 1'b0;
      dmemWEN     = 1'b0;
      mem_stall   = 1'b0;
      memwb_flush = 1'b0;
      complete    = 1'b0;
      sc_now      = 1'b0;
      sc_fail     = 1'b0;
      load_data   = load_data_reg;
      case (state_reg)
         IDLE: begin
            if (mem_op) begin
               dmemREN = req_ren & ~sc_bad;
               dmemWEN = req_wen & ~sc_bad;
               if (dhit || sc_bad) begin
                  complete = 1'b1;
                  sc_now   = sc_bad;
               end else begin
                  mem_stall   = 1'b1;
                  memwb_flush = 1'b1;
                  state_next  = WAIT;
               end
            end
         end
         WAIT: begin
            dmemREN = req_ren;
            dmemWEN = req_wen;
            if (dhit) begin
               complete = 1'b1;
            end else begin
               mem_stall   = 1'b1;
               memwb_flush = 1'b1;
            end
         end
         DONE: begin
            memwb_flush = 1'b1;
            sc_fail     = sc_fail_reg;
            if (latch_adv) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (complete) begin
         load_data  = dmemload;
         sc_fail    = sc_now;
         state_next = latch_adv ? IDLE : DONE;
      end
      // Requests must drop the moment reset asserts, not at the next edge.
      if (!nRST) begin
         dmemREN     = 1'b0;
         dmemWEN     = 1'b0;
         mem_stall   = 1'b0;
         memwb_flush = 1'b0;
         sc_fail     = 1'b0;
         load_data   = 32'h0;
      end
   end

   always_comb begin
      link_valid_next = link_valid_reg;
      link_addr_next  = link_addr_reg;
      load_data_next  = complete ? dmemload : load_data_reg;
      sc_fail_next    = complete ? sc_now : sc_fail_reg;
      stall_cnt_next  = stall_cnt_reg;
      if (mem_stall && stall_cnt_reg != {CNT_W{1'b1}})
         stall_cnt_next = stall_cnt_reg + CNT_W'(1);
      if (complete) begin
         if (is_sc) begin
            link_valid_next = 1'b0;
         end else if (is_lr) begin
            link_valid_next = 1'b1;
            link_addr_next  = req_addr;
         end else if (req_wen && req_addr[31:2] == link_addr_reg[31:2]) begin
            link_valid_next = 1'b0;
         end
      end
      // A snoop beats everything, including an LR to the snooped word completing now.
      if (snoop_inval && ((snoop_addr[31:2] == link_addr_reg[31:2]) ||
                          (complete && is_lr && snoop_addr[31:2] == req_addr[31:2])))
         link_valid_next = 1'b0;
      if (req_valid && req_halt)
         link_valid_next = 1'b0;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg      <= IDLE;
         link_valid_reg <= 1'b0;
         link_addr_reg  <= 32'h0;
         load_data_reg  <= 32'h0;
         sc_fail_reg    <= 1'b0;
         stall_cnt_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         link_valid_reg <= link_valid_next;
         link_addr_reg  <= link_addr_next;
         load_data_reg  <= load_data_next;
         sc_fail_reg    <= sc_fail_next;
         stall_cnt_reg  <= stall_cnt_next;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; expected load results travel through a scoreboard queue.
module tb_mem_access_ctrl;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        req_valid, req_ren, req_wen, req_atomic, req_halt;
   logic [31:0] req_addr, req_store;
   logic        latch_adv, dhit;
   logic [31:0] dmemload;
   logic        snoop_inval;
   logic [31:0] snoop_addr;
   logic        dmemREN, dmemWEN;
   logic [31:0] dmemaddr, dmemstore, load_data;
   logic        sc_fail, mem_stall, memwb_flush, link_valid;
   logic [31:0] link_addr;
   logic [15:0] stall_cycles;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] sb_q[$];
   int wen_cnt;

   always #5 CLK = ~CLK;

   mem_access_ctrl #(.CNT_W(16)) dut (
      .CLK(CLK), .nRST(nRST),
      .req_valid(req_valid), .req_ren(req_ren), .req_wen(req_wen),
      .req_atomic(req_atomic), .req_halt(req_halt),
      .req_addr(req_addr), .req_store(req_store),
      .latch_adv(latch_adv), .dhit(dhit), .dmemload(dmemload),
      .snoop_inval(snoop_inval), .snoop_addr(snoop_addr),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .load_data(load_data), .sc_fail(sc_fail),
      .mem_stall(mem_stall), .memwb_flush(memwb_flush),
      .link_valid(link_valid), .link_addr(link_addr),
      .stall_cycles(stall_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-14s observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_load(input string tag);
      logic [31:0] exp;
      if (sb_q.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, load_data);
      end else begin
         exp = sb_q.pop_front();
         chk(tag, load_data, exp);
      end
   endtask

   task automatic idle_inputs();
      req_valid = 0; req_ren = 0; req_wen = 0; req_atomic = 0; req_halt = 0;
      req_addr = 0; req_store = 0; latch_adv = 1; dhit = 0; dmemload = 0;
      snoop_inval = 0; snoop_addr = 0;
   endtask

   task automatic drive(input logic ren, input logic wen, input logic atomic,
                        input logic [31:0] addr, input logic hit, input logic adv);
      req_valid = 1; req_ren = ren; req_wen = wen; req_atomic = atomic;
      req_addr = addr; dhit = hit; latch_adv = adv;
   endtask

   initial begin
      idle_inputs();
      nRST = 0;
      #1;
      chk("rst_ren",    32'(dmemREN), 32'd0);
      chk("rst_stall",  32'(mem_stall), 32'd0);
      chk("rst_link",   32'(link_valid), 32'd0);
      chk("rst_cnt",    32'(stall_cycles), 32'd0);
      chk("rst_ldata",  load_data, 32'd0);
      @(negedge CLK); nRST = 1;

      // Load hit
      @(negedge CLK);
      drive(1, 0, 0, 32'h100, 1, 1); dmemload = 32'hDEADBEEF;
      sb_q.push_back(32'hDEADBEEF);
      #1;
      chk("lh_ren",   32'(dmemREN), 32'd1);
      chk("lh_stall", 32'(mem_stall), 32'd0);
      chk("lh_flush", 32'(memwb_flush), 32'd0);
      chk_load("lh_data");
      @(negedge CLK); idle_inputs();
      #1 chk("lh_cnt", 32'(stall_cycles), 32'd0);

      // Store miss, dhit three cycles after issue
      wen_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         drive(0, 1, 0, 32'h200, i == 3, i == 3); req_store = 32'h12345678;
         #1;
         if (dmemWEN) wen_cnt++;
         chk("sm_stall", 32'(mem_stall), 32'(i < 3));
         chk("sm_flush", 32'(memwb_flush), 32'(i < 3));
         chk("sm_addr",  dmemaddr, 32'h200);
      end
      @(negedge CLK); idle_inputs();
      #1;
      chk("sm_wen_cyc", 32'(wen_cnt), 32'd4);
      chk("sm_cnt",     32'(stall_cycles), 32'd3);
      chk("sm_wen_off", 32'(dmemWEN), 32'd0);

      // LR then SC
      @(negedge CLK);
      drive(1, 0, 1, 32'h300, 1, 1); dmemload = 32'h000000AA;
      sb_q.push_back(32'h000000AA);
      #1 chk_load("lr_data");
      @(negedge CLK);
      drive(0, 1, 1, 32'h300, 1, 1);
      #1;
      chk("lr_link",   32'(link_valid), 32'd1);
      chk("lr_addr",   link_addr, 32'h300);
      chk("sc_wen",    32'(dmemWEN), 32'd1);
      chk("sc_fail0",  32'(sc_fail), 32'd0);
      @(negedge CLK); idle_inputs();
      #1 chk("sc_clr", 32'(link_valid), 32'd0);

      // Snoop breaks the reservation; following SC fails without touching the cache
      @(negedge CLK);
      drive(1, 0, 1, 32'h300, 1, 1); dmemload = 32'h55;
      sb_q.push_back(32'h55);
      #1 chk_load("lr2_data");
      @(negedge CLK); idle_inputs();
      snoop_inval = 1; snoop_addr = 32'h303;
      #1 chk("sn_before", 32'(link_valid), 32'd1);
      @(negedge CLK); idle_inputs();
      drive(0, 1, 1, 32'h300, 0, 1);
      #1;
      chk("sn_link",   32'(link_valid), 32'd0);
      chk("scf_wen",   32'(dmemWEN), 32'd0);
      chk("scf_fail",  32'(sc_fail), 32'd1);
      chk("scf_stall", 32'(mem_stall), 32'd0);
      @(negedge CLK); idle_inputs();
      #1 chk("scf_cnt", 32'(stall_cycles), 32'd3);

      // Held latch: two DONE cycles
      @(negedge CLK);
      drive(1, 0, 0, 32'h400, 1, 0); dmemload = 32'hCAFEF00D;
      sb_q.push_back(32'hCAFEF00D);
      sb_q.push_back(32'hCAFEF00D);
      sb_q.push_back(32'hCAFEF00D);
      #1 chk_load("hl_data");
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         dhit = 0; dmemload = 32'h11111111; latch_adv = (i == 1);
         #1;
         chk("hl_ren",   32'(dmemREN), 32'd0);
         chk("hl_flush", 32'(memwb_flush), 32'd1);
         chk("hl_stall", 32'(mem_stall), 32'd0);
         chk_load("hl_held");
      end
      @(negedge CLK); idle_inputs();
      #1 chk("hl_exit", 32'(memwb_flush), 32'd0);

      // Reset while waiting on a miss
      @(negedge CLK);
      drive(1, 0, 1, 32'h500, 1, 1); dmemload = 32'h77;
      sb_q.push_back(32'h77);
      #1 chk_load("lr3_data");
      @(negedge CLK);
      drive(1, 0, 0, 32'h600, 0, 0);
      #1 chk("rw_stall0", 32'(mem_stall), 32'd1);
      @(negedge CLK);
      #1;
      chk("rw_ren",   32'(dmemREN), 32'd1);
      chk("rw_link",  32'(link_valid), 32'd1);
      chk("rw_cnt",   32'(stall_cycles), 32'd4);
      nRST = 0;
      #1;
      chk("rw_ren0",   32'(dmemREN), 32'd0);
      chk("rw_stall1", 32'(mem_stall), 32'd0);
      chk("rw_link0",  32'(link_valid), 32'd0);
      @(negedge CLK);
      nRST = 1; idle_inputs();
      #1;
      chk("rw_cnt0",   32'(stall_cycles), 32'd0);
      chk("rw_flush",  32'(memwb_flush), 32'd0);
      @(negedge CLK);
      drive(1, 0, 0, 32'h700, 1, 1); dmemload = 32'h0BADF00D;
      sb_q.push_back(32'h0BADF00D);
      #1;
      chk("post_stall", 32'(mem_stall), 32'd0);
      chk_load("post_data");
      @(negedge CLK); idle_inputs();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
